// File: rtl/kbd_pkg.sv
// Shared scancode constants, intake FSM state type and the Set-2 to ASCII lookup
// for the keyboard scancode decoder.
package kbd_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      StIdle,
      StAck,
      StWaitClr
   } intake_state_e;

   typedef struct packed {
      logic       valid;
      logic [7:0] ascii;
   } lookup_t;

   function automatic lookup_t ascii_lookup(input logic [7:0] code, input logic shift,
                                            input logic caps);
      lookup_t    r;
      logic [7:0] letter;
      r      = '0;
      letter = '0;
      case (code)
         8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
         8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
         8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
         8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
         8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
         8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
         8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
         8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
         8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
         8'h45: r = '{valid: 1'b1, ascii: shift ? 8'h29 : 8'h30};
         8'h16: r = '{valid: 1'b1, ascii: shift ? 8'h21 : 8'h31};
         8'h1E: r = '{valid: 1'b1, ascii: shift ? 8'h40 : 8'h32};
         8'h26: r = '{valid: 1'b1, ascii: shift ? 8'h23 : 8'h33};
         8'h25: r = '{valid: 1'b1, ascii: shift ? 8'h24 : 8'h34};
         8'h2E: r = '{valid: 1'b1, ascii: shift ? 8'h25 : 8'h35};
         8'h36: r = '{valid: 1'b1, ascii: shift ? 8'h5E : 8'h36};
         8'h3D: r = '{valid: 1'b1, ascii: shift ? 8'h26 : 8'h37};
         8'h3E: r = '{valid: 1'b1, ascii: shift ? 8'h2A : 8'h38};
         8'h46: r = '{valid: 1'b1, ascii: shift ? 8'h28 : 8'h39};
         8'h29: r = '{valid: 1'b1, ascii: 8'h20};
         8'h5A: r = '{valid: 1'b1, ascii: 8'h0D};
         8'h66: r = '{valid: 1'b1, ascii: 8'h08};
         8'h0D: r = '{valid: 1'b1, ascii: 8'h09};
         default: r = '0;
      endcase
      if (letter != 8'h00) begin
         r.valid = 1'b1;
         r.ascii = (shift ^ caps) ? letter - 8'h20 : letter;
      end
      return r;
   endfunction

endpackage

// File: rtl/kbd_fifo.sv
// First-word fall-through FIFO; full/empty told apart by an extra pointer bit.
module kbd_fifo #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 8
) (
   input  logic             fclk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AW:0]      wptr_q, rptr_q;
   logic             do_push, do_pop;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees a slot, so a push while full still lands.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge fclk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
            wptr_q                <= wptr_q + (AW+1)'(1);
         end
         if (do_pop) rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/kbd_scancode_decoder.sv
// PS/2 Set-2 scancode to ASCII decoder with character FIFO.
// Optional KBD_BREAK_EVENTS_EN: also queue key releases with data_out[8] set.
module kbd_scancode_decoder
   import kbd_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic       fclk,
   input  logic       rst,
   input  logic [7:0] code_in,
   input  logic       code_valid,
   output logic       code_ack,
   input  logic       rd,
   output logic [8:0] data_out,
   output logic       data_avail,
   output logic       overflow,
   input  logic       ovf_clr
);

`ifdef KBD_BREAK_EVENTS_EN
   localparam int unsigned FW = 9;
`else
   localparam int unsigned FW = 8;
`endif

   intake_state_e state_q;
   logic [7:0]    code_q;
   logic          ack_q, ext_pend_q, brk_pend_q, shift_l_q, shift_r_q, caps_q, ovf_q;
   lookup_t       lk;
   logic          is_prefix, push, full, empty, drop;
   logic [FW-1:0] wdata, rdata;

   always_comb begin
      lk        = ascii_lookup(code_q, shift_l_q | shift_r_q, caps_q);
      is_prefix = (code_q == SC_EXT) || (code_q == SC_BREAK);
`ifdef KBD_BREAK_EVENTS_EN
      push      = (state_q == StAck) && !is_prefix && !ext_pend_q && lk.valid;
      wdata     = {brk_pend_q, lk.ascii};
      data_out  = rdata;
`else
      push      = (state_q == StAck) && !is_prefix && !ext_pend_q && !brk_pend_q && lk.valid;
      wdata     = lk.ascii;
      data_out  = {1'b0, rdata};
`endif
      drop      = push & full & ~rd;
   end

   always_ff @(posedge fclk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         code_q     <= '0;
         ack_q      <= 1'b0;
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         shift_l_q  <= 1'b0;
         shift_r_q  <= 1'b0;
         caps_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (code_valid) begin
                  code_q  <= code_in;
                  ack_q   <= 1'b1;
                  state_q <= StAck;
               end
            end
            StAck: begin
               ack_q   <= 1'b0;
               state_q <= StWaitClr;
               if (code_q == SC_EXT) begin
                  ext_pend_q <= 1'b1;
               end else if (code_q == SC_BREAK) begin
                  brk_pend_q <= 1'b1;
               end else begin
                  ext_pend_q <= 1'b0;
                  brk_pend_q <= 1'b0;
                  // Extended events, including the fake shift E0 12, leave modifiers alone.
                  if (!ext_pend_q) begin
                     if (code_q == SC_LSHIFT) shift_l_q <= ~brk_pend_q;
                     if (code_q == SC_RSHIFT) shift_r_q <= ~brk_pend_q;
                     if (code_q == SC_CAPS && !brk_pend_q) caps_q <= ~caps_q;
                  end
               end
            end
            StWaitClr: if (!code_valid) state_q <= StIdle;
            default:   state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge fclk or negedge rst) begin
      if (!rst)         ovf_q <= 1'b0;
      else if (drop)    ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
   end

   kbd_fifo #(
      .Depth (DEPTH),
      .Width (FW)
   ) u_fifo (
      .fclk  (fclk),
      .rst   (rst),
      .push  (push),
      .wdata (wdata),
      .pop   (rd),
      .rdata (rdata),
      .full  (full),
      .empty (empty)
   );

   assign code_ack   = ack_q;
   assign data_avail = ~empty;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// Directed self-checking bench for kbd_scancode_decoder (default DEPTH=8).
module tb_kbd_scancode_decoder;

   logic       fclk = 1'b0;
   logic       rst  = 1'b0;
   logic [7:0] code_in = '0;
   logic       code_valid = 1'b0;
   logic       code_ack;
   logic       rd = 1'b0;
   logic [8:0] data_out;
   logic       data_avail;
   logic       overflow;
   logic       ovf_clr = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 fclk = ~fclk;

   kbd_scancode_decoder #(.DEPTH(8)) dut (
      .fclk       (fclk),
      .rst        (rst),
      .code_in    (code_in),
      .code_valid (code_valid),
      .code_ack   (code_ack),
      .rd         (rd),
      .data_out   (data_out),
      .data_avail (data_avail),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   task automatic send_code(input logic [7:0] c, input logic with_rd);
      bit got = 0;
      @(negedge fclk);
      code_in    = c;
      code_valid = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge fclk); #1;
         if (code_ack === 1'b1) got = 1;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL ack_%h: code_ack=%b, required 1 within 10 cycles", c, code_ack);
      end
      if (with_rd) rd = 1'b1;
      code_valid = 1'b0;
      @(posedge fclk); #1;
      rd = 1'b0;
      @(posedge fclk); #1;
   endtask

   task automatic expect_pop(input logic [8:0] exp, input string name);
      total++;
      if (data_avail !== 1'b1 || data_out !== exp) begin
         bad++;
         $display("FAIL %s: avail=%b data_out=%h, required avail=1 data_out=%h",
                  name, data_avail, data_out, exp);
      end
      @(negedge fclk); rd = 1'b1;
      @(posedge fclk); #1; rd = 1'b0;
   endtask

   task automatic expect_empty(input string name);
      total++;
      if (data_avail !== 1'b0) begin
         bad++;
         $display("FAIL %s: avail=%b data_out=%h, required avail=0", name, data_avail, data_out);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge fclk);
      #1;
      total++;
      if (code_ack !== 1'b0 || data_avail !== 1'b0 || data_out !== 9'h000 || overflow !== 1'b0)
      begin
         bad++;
         $display("FAIL reset: ack=%b avail=%b data=%h ovf=%b, required 0 0 000 0",
                  code_ack, data_avail, data_out, overflow);
      end
      @(negedge fclk); rst = 1'b1;
      @(posedge fclk); #1;
   endtask

   task automatic test_timing;
      @(negedge fclk);
      code_in = 8'h1C; code_valid = 1'b1;
      @(posedge fclk); #1;
      total++;
      if (code_ack !== 1'b1 || data_avail !== 1'b0) begin
         bad++;
         $display("FAIL timing_n1: ack=%b avail=%b, required ack=1 avail=0", code_ack, data_avail);
      end
      @(posedge fclk); #1;
      total++;
      if (code_ack !== 1'b0 || data_avail !== 1'b1 || data_out !== 9'h061) begin
         bad++;
         $display("FAIL timing_n2: ack=%b avail=%b data=%h, required 0 1 061",
                  code_ack, data_avail, data_out);
      end
      // Holding code_valid must not consume the code again.
      repeat (3) @(posedge fclk);
      code_valid = 1'b0;
      repeat (2) @(posedge fclk); #1;
      expect_pop(9'h061, "timing_head");
      expect_empty("timing_single");
   endtask

   task automatic test_shift;
      send_code(8'h12, 0); send_code(8'h1C, 0);
      send_code(8'hF0, 0); send_code(8'h12, 0); send_code(8'h1C, 0);
      expect_pop(9'h041, "shift_A");
      expect_pop(9'h061, "shift_released_a");
      expect_empty("shift_end");
   endtask

   task automatic test_caps_digits;
      send_code(8'h58, 0); send_code(8'hF0, 0); send_code(8'h58, 0);
      send_code(8'h16, 0);
      send_code(8'h12, 0); send_code(8'h16, 0);
      send_code(8'hF0, 0); send_code(8'h12, 0);
      send_code(8'h1C, 0);
      send_code(8'h12, 0); send_code(8'h1C, 0);
      send_code(8'hF0, 0); send_code(8'h12, 0);
      send_code(8'h58, 0); send_code(8'h1C, 0);
      expect_pop(9'h031, "caps_digit_1");
      expect_pop(9'h021, "shift_digit_bang");
      expect_pop(9'h041, "caps_A");
      expect_pop(9'h061, "caps_shift_a");
      expect_pop(9'h061, "caps_off_a");
      expect_empty("caps_end");
      send_code(8'h29, 0); send_code(8'h5A, 0); send_code(8'h66, 0); send_code(8'h0D, 0);
      send_code(8'h76, 0); send_code(8'h12, 0); send_code(8'h45, 0);
      send_code(8'hF0, 0); send_code(8'h12, 0); send_code(8'h1A, 0);
      expect_pop(9'h020, "space");
      expect_pop(9'h00D, "enter");
      expect_pop(9'h008, "backspace");
      expect_pop(9'h009, "tab");
      expect_pop(9'h029, "shift_digit_0");
      expect_pop(9'h07A, "z");
      expect_empty("unmapped_end");
   endtask

   task automatic test_extended;
      send_code(8'hE0, 0); send_code(8'h75, 0);
      send_code(8'hE0, 0); send_code(8'h12, 0);
      expect_empty("ext_discard");
      send_code(8'h1C, 0);
      expect_pop(9'h061, "ext_no_shift");
   endtask

   task automatic test_overflow;
      logic [7:0] codes [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
      logic [8:0] exp   [8] = '{9'h062, 9'h063, 9'h064, 9'h065, 9'h066, 9'h067, 9'h068, 9'h078};
      for (int i = 0; i < 9; i++) send_code(codes[i], 0);
      total++;
      if (overflow !== 1'b1 || data_avail !== 1'b1 || data_out !== 9'h061) begin
         bad++;
         $display("FAIL ovf_set: ovf=%b avail=%b data=%h, required 1 1 061",
                  overflow, data_avail, data_out);
      end
      @(negedge fclk); ovf_clr = 1'b1;
      @(posedge fclk); #1; ovf_clr = 1'b0;
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clr: ovf=%b, required 0", overflow);
      end
      send_code(8'h22, 1);
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_push_rd_full: ovf=%b, required 0", overflow);
      end
      for (int i = 0; i < 8; i++) expect_pop(exp[i], $sformatf("drain_%0d", i));
      expect_empty("drain_end");
   endtask

   task automatic test_back_to_back;
      @(negedge fclk); rd = 1'b1;
      @(posedge fclk); #1; rd = 1'b0;
      expect_empty("rd_when_empty");
      send_code(8'h1C, 1);
      expect_pop(9'h061, "push_rd_empty");
      expect_empty("push_rd_empty_end");
   endtask

   task automatic test_reset_midseq;
      send_code(8'hF0, 0);
      @(negedge fclk); rst = 1'b0;
      @(posedge fclk);
      @(negedge fclk); rst = 1'b1;
      send_code(8'h1C, 0);
      expect_pop(9'h061, "rst_midseq_make");
      expect_empty("rst_midseq_end");
      send_code(8'h1C, 0); send_code(8'hF0, 0); send_code(8'h1C, 0);
      expect_pop(9'h061, "brk_make");
`ifdef KBD_BREAK_EVENTS_EN
      expect_pop(9'h161, "brk_release");
`endif
      expect_empty("brk_end");
   endtask

   initial begin
      test_reset;
      test_timing;
      test_shift;
      test_caps_digits;
      test_extended;
      test_overflow;
      test_back_to_back;
      test_reset_midseq;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/kbd_scancode_decoder.md
# kbd_scancode_decoder

Downstream consumer of the PS/2 keyboard receiver. Takes each 8-bit Set-2 scancode the receiver presents with its ready flag, acknowledges it, and tracks break (F0) and extended (E0) prefixes plus Shift and Caps Lock state. Translates make codes to ASCII and buffers the characters in a small FIFO, which the CPU's memory-mapped keyboard port reads.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..16
- fclk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- code_in  in  8  scancode from the receiver; stable while code_valid=1
- code_valid  in  1  receiver data-ready level
- code_ack  out  1  one-cycle read strobe back to the receiver (its rdn)
- rd  in  1  CPU pop strobe, one cycle
- data_out  out  9  FIFO head; [7:0] ASCII, [8] release flag
- data_avail  out  1  FIFO non-empty
- overflow  out  1  sticky: a character was dropped because the FIFO was full
- ovf_clr  in  1  clears overflow

## Operation
- Intake FSM states:
  - IDLE: code_valid=1 → latch code_in, go to ACK.
  - ACK: code_ack=1 for exactly this cycle; decode the latched code; go to WAIT_CLR.
  - WAIT_CLR: stay until code_valid=0, then go to IDLE. This prevents a code from being consumed twice.
- Decode, in ACK:
  - E0 → set ext_pend.
  - F0 → set brk_pend.
  - Any other code completes an event. ext_pend and brk_pend are cleared after the event.
- Extended events (ext_pend=1) are discarded, including the fake shift E0 12.
- Shift: shift_l is set by make of 12 and cleared by its break. shift_r is set by make of 59 and cleared by its break. shift = shift_l | shift_r.
- Caps Lock (58): each make toggles caps. Break is ignored. Typematic repeat makes also toggle.
- ASCII map:
  - Letters: lowercase if shift^caps = 0, otherwise uppercase.
  - Digits 0–9: unshifted gives '0'–'9'. Shifted gives US symbols ")!@#$%^&*(".
  - 29 → 0x20. 5A → 0x0D. 66 → 0x08. 0D → 0x09.
  - Every other code is unmapped and produces nothing.
- Make of a mapped key pushes {1'b0, ascii}.
- Modifier keys (12, 59, 58) never push.
- FIFO behaviour:
  - First-word fall-through: data_out is valid whenever data_avail=1, and rd pops the head.
  - rd when empty is ignored.
  - Push when full: the character is dropped and overflow is set.
  - Simultaneous push and rd when full: both take effect, no overflow.
  - Simultaneous push and rd when empty: the push takes effect and rd is ignored.
  - Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
- overflow: set has priority over ovf_clr in the same cycle.
- Reset values:
  - FSM = IDLE, code_ack = 0.
  - FIFO empty, data_avail = 0, data_out = 0.
  - overflow = 0.
  - shift_l, shift_r, caps, brk_pend, ext_pend all 0.
- Reset mid-sequence (e.g. after F0, before the key code) discards the pending prefix. The next code is treated as a make.

## Timing
- code_valid sampled 1 in IDLE at cycle N → code_ack=1 at N+1 → FIFO write at end of N+1 → data_avail=1 at N+2.
- Minimum spacing between consumed codes: 3 cycles plus the receiver's deassert time.
- rd at cycle M → the new head (or data_avail=0) is visible at M+1.
- overflow is set the cycle after the dropped push.
- All outputs are registered except data_out, which is a combinational read of the head entry.

## Configuration
- KBD_BREAK_EVENTS_EN:
  - Defined: break of a mapped key pushes {1'b1, ascii}, using the same shift/caps state as the make would. Breaks of modifiers still never push.
  - Undefined: breaks push nothing and data_out[8] is tied 0. FIFO storage is 8 bits wide.

## Structure
- Package kbd_pkg holds:
  - Scancode constants: SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58.
  - The intake FSM state enum.
  - The ascii_lookup function (code, shift, caps → valid, ascii).
- Sub-module kbd_fifo: a parameterised FWFT FIFO with push, pop, full, empty and a width parameter.

## Test plan
- Reset; present 1C → code_ack pulse at N+1; data_out=0x061 ('a'); data_avail=1 at N+2.
- Sequence 12, 1C, F0 12, 1C → FIFO contains 'A', then 'a'. shift_l=0 at the end.
- Sequence 58, F0 58, 16, then 12 16 → '1' becomes... correction: caps only; expected output is '1' then '!'. Separately, 58 then 1C → 'A'. Then 12 1C → 'a' (shift^caps).
- Sequence E0 75 and E0 12 → nothing pushed; shift stays 0. Next 1C → 'a'.
- DEPTH=8: push 9 chars with no rd → 8 stored, overflow=1. rd and push in the same cycle while full → no new overflow. ovf_clr → overflow=0.
- F0 followed by rst low, then 1C → 'a' pushed as a make. With KBD_BREAK_EVENTS_EN defined, 1C F0 1C → 0x061 then 0x161.
